// File: rtl/tile_pixel_scheduler_pkg.sv
// Shared constants and types for the tile/sprite pixel scheduler.
// The tile edge must be a power of two: offsets and tile indices are taken as bit fields.
package tile_pixel_scheduler_pkg;

    localparam int TILE_SIZE = 8;
    localparam int TILE_W    = $clog2(TILE_SIZE);
    localparam int TILE_AREA = TILE_SIZE * TILE_SIZE;
    localparam int PIX_OFF_W = 2 * TILE_W;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        TILE_EMPTY   = 2'd0,
        TILE_WALL    = 2'd1,
        TILE_DOT     = 2'd2,
        TILE_BIG_DOT = 2'd3
    } tile_code_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_PLAYER = '{r: 4'hF, g: 4'hF, b: 4'h0};
    localparam rgb_t RGB_GHOST  = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_DOT    = '{r: 4'hF, g: 4'hF, b: 4'hF};

    function automatic rgb_t plane_rgb(
        input logic [TILE_AREA*4-1:0] pr,
        input logic [TILE_AREA*4-1:0] pg,
        input logic [TILE_AREA*4-1:0] pb,
        input logic [PIX_OFF_W-1:0]   p
    );
        rgb_t c;
        c.r = pr[{p, 2'b00} +: 4];
        c.g = pg[{p, 2'b00} +: 4];
        c.b = pb[{p, 2'b00} +: 4];
        return c;
    endfunction

endpackage

// File: rtl/tile_pixel_scheduler_sprite_hit.sv
// Decides whether one pixel falls on an opaque texel of one T x T sprite.
// Positions are unsigned screen coordinates; no wrap-around at the screen edge.
module tile_pixel_scheduler_sprite_hit
    import tile_pixel_scheduler_pkg::*;
(
    input  logic [COORD_W-1:0]   px,
    input  logic [COORD_W-1:0]   py,
    input  logic [COORD_W-1:0]   sx,
    input  logic [COORD_W-1:0]   sy,
    input  logic [TILE_AREA-1:0] mask,
    output logic                 hit
);

    logic signed [COORD_W:0] dx_s;
    logic signed [COORD_W:0] dy_s;
    logic                    in_tile_s;

    // Sign bit and all bits above the tile field zero means 0 <= d < T.
    always_comb begin
        dx_s      = $signed({1'b0, px}) - $signed({1'b0, sx});
        dy_s      = $signed({1'b0, py}) - $signed({1'b0, sy});
        in_tile_s = (dx_s[COORD_W:TILE_W] == {(COORD_W + 1 - TILE_W){1'b0}}) &&
                    (dy_s[COORD_W:TILE_W] == {(COORD_W + 1 - TILE_W){1'b0}});
        hit       = in_tile_s && mask[{dy_s[TILE_W-1:0], dx_s[TILE_W-1:0]}];
    end

endmodule

// File: rtl/tile_pixel_scheduler.sv
// Per-pixel render controller: map fetch, sprite compositing and animation phase.
// Pixel in at cycle n produces rgb_valid at n+2, one pixel per cycle.
module tile_pixel_scheduler
    import tile_pixel_scheduler_pkg::*;
#(
    parameter int MAP_W       = 28,
    parameter int MAP_H       = 31,
    parameter int NUM_GHOSTS  = 4,
    parameter int ANIM_FRAMES = 8,
    parameter int AW          = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [COORD_W-1:0]            pix_x,
    input  logic [COORD_W-1:0]            pix_y,
    output logic [AW-1:0]                 map_addr,
    input  logic [1:0]                    map_data,
    input  logic [COORD_W-1:0]            player_x,
    input  logic [COORD_W-1:0]            player_y,
    input  logic [COORD_W*NUM_GHOSTS-1:0] ghost_x,
    input  logic [COORD_W*NUM_GHOSTS-1:0] ghost_y,
    input  logic [TILE_AREA*4-1:0]        background_r,
    input  logic [TILE_AREA*4-1:0]        background_g,
    input  logic [TILE_AREA*4-1:0]        background_b,
    input  logic [TILE_AREA*4-1:0]        wall_r,
    input  logic [TILE_AREA*4-1:0]        wall_g,
    input  logic [TILE_AREA*4-1:0]        wall_b,
    input  logic [TILE_AREA-1:0]          player_mask_f1,
    input  logic [TILE_AREA-1:0]          player_mask_f2,
    input  logic [TILE_AREA-1:0]          ghost_mask_f1,
    input  logic [TILE_AREA-1:0]          ghost_mask_f2,
    input  logic [TILE_AREA-1:0]          dot_mask,
    input  logic [TILE_AREA-1:0]          big_dot_mask,
    output logic [3:0]                    rgb_r,
    output logic [3:0]                    rgb_g,
    output logic [3:0]                    rgb_b,
    output logic                          rgb_valid,
    output logic                          anim_phase
);

    localparam int TCOORD_W = COORD_W - TILE_W;
    localparam int CNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

    logic [TCOORD_W-1:0]  tile_x_s;
    logic [TCOORD_W-1:0]  tile_y_s;
    logic [AW-1:0]        addr_s;
    logic                 oom_s;
    logic [PIX_OFF_W-1:0] off_s;

    logic                 s1_valid_r;
    logic [COORD_W-1:0]   s1_x_r;
    logic [COORD_W-1:0]   s1_y_r;
    logic [PIX_OFF_W-1:0] s1_off_r;
    logic                 s1_oom_r;
    logic                 s1_phase_r;
    logic [CNT_W-1:0]     anim_cnt_r;

    logic [TILE_AREA-1:0]  player_mask_s;
    logic [TILE_AREA-1:0]  ghost_mask_s;
    logic                  player_hit_s;
    logic [NUM_GHOSTS-1:0] ghost_hit_s;
    tile_code_e            tile_s;
    rgb_t                  bg_s;
    rgb_t                  pix_s;

    // S0 address/offset decode; out-of-map addresses are don't-care but still registered.
    always_comb begin
        tile_x_s = pix_x[COORD_W-1:TILE_W];
        tile_y_s = pix_y[COORD_W-1:TILE_W];
        addr_s   = AW'(int'(tile_y_s) * MAP_W + int'(tile_x_s));
        oom_s    = (int'(tile_x_s) >= MAP_W) || (int'(tile_y_s) >= MAP_H);
        off_s    = {pix_y[TILE_W-1:0], pix_x[TILE_W-1:0]};
    end

    // S0 -> S1 pipeline register; the phase is captured here so a coincident frame_start cannot split a pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_addr   <= {AW{1'b0}};
            s1_valid_r <= 1'b0;
            s1_x_r     <= {COORD_W{1'b0}};
            s1_y_r     <= {COORD_W{1'b0}};
            s1_off_r   <= {PIX_OFF_W{1'b0}};
            s1_oom_r   <= 1'b0;
            s1_phase_r <= 1'b0;
        end else begin
            s1_valid_r <= pix_valid;
            if (pix_valid) begin
                map_addr   <= addr_s;
                s1_x_r     <= pix_x;
                s1_y_r     <= pix_y;
                s1_off_r   <= off_s;
                s1_oom_r   <= oom_s;
                s1_phase_r <= anim_phase;
            end
        end
    end

    // Animation frame counter; phase flips when a pulse arrives with the counter at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_cnt_r <= {CNT_W{1'b0}};
            anim_phase <= 1'b0;
        end else if (frame_start) begin
            if (anim_cnt_r == CNT_LAST) begin
                anim_cnt_r <= {CNT_W{1'b0}};
                anim_phase <= ~anim_phase;
            end else begin
                anim_cnt_r <= anim_cnt_r + CNT_W'(1);
            end
        end
    end

    // Mask set selection for the pixel currently in S1.
    always_comb begin
        if (s1_phase_r) begin
            player_mask_s = player_mask_f2;
            ghost_mask_s  = ghost_mask_f2;
        end else begin
            player_mask_s = player_mask_f1;
            ghost_mask_s  = ghost_mask_f1;
        end
    end

    tile_pixel_scheduler_sprite_hit u_player_hit (
        .px   (s1_x_r),
        .py   (s1_y_r),
        .sx   (player_x),
        .sy   (player_y),
        .mask (player_mask_s),
        .hit  (player_hit_s)
    );

    for (genvar k = 0; k < NUM_GHOSTS; k++) begin : g_ghost
        tile_pixel_scheduler_sprite_hit u_ghost_hit (
            .px   (s1_x_r),
            .py   (s1_y_r),
            .sx   (ghost_x[k*COORD_W +: COORD_W]),
            .sy   (ghost_y[k*COORD_W +: COORD_W]),
            .mask (ghost_mask_s),
            .hit  (ghost_hit_s[k])
        );
    end

    // S1 priority mux: player, ghosts, wall, dots, background.
    always_comb begin
        tile_s = TILE_EMPTY;
        bg_s   = RGB_BLACK;
        pix_s  = RGB_BLACK;
        if (s1_oom_r) begin
            tile_s = TILE_EMPTY;
            bg_s   = RGB_BLACK;
        end else begin
            tile_s = tile_code_e'(map_data);
            bg_s   = plane_rgb(background_r, background_g, background_b, s1_off_r);
        end
        if (player_hit_s) begin
            pix_s = RGB_PLAYER;
        end else if (|ghost_hit_s) begin
            pix_s = RGB_GHOST;
        end else begin
            case (tile_s)
                TILE_WALL:    pix_s = plane_rgb(wall_r, wall_g, wall_b, s1_off_r);
                TILE_DOT:     pix_s = dot_mask[s1_off_r] ? RGB_DOT : bg_s;
                TILE_BIG_DOT: pix_s = big_dot_mask[s1_off_r] ? RGB_DOT : bg_s;
                TILE_EMPTY:   pix_s = bg_s;
                default:      pix_s = bg_s;
            endcase
        end
    end

    // S2 output register; colour holds across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_valid <= 1'b0;
            rgb_r     <= 4'h0;
            rgb_g     <= 4'h0;
            rgb_b     <= 4'h0;
        end else begin
            rgb_valid <= s1_valid_r;
            if (s1_valid_r) begin
                rgb_r <= pix_s.r;
                rgb_g <= pix_s.g;
                rgb_b <= pix_s.b;
            end
        end
    end

endmodule

// File: tb/tb_tile_pixel_scheduler.sv
// Scoreboard bench for tile_pixel_scheduler: directed scenes plus randomized pixel streams
// checked against a coordinate-level reference model.
module tb_tile_pixel_scheduler;
    import tile_pixel_scheduler_pkg::*;

    localparam int MAP_W = 28;
    localparam int MAP_H = 31;
    localparam int NG    = 4;
    localparam int AF    = 2;
    localparam int AW    = 10;
    localparam int T     = TILE_SIZE;
    localparam int TT    = TILE_AREA;
    localparam int MAP_N = MAP_W * MAP_H;
    localparam int PARK  = 600;

    logic clk, rst_n, frame_start, pix_valid;
    logic [9:0] pix_x, pix_y, player_x, player_y;
    logic [AW-1:0] map_addr;
    logic [1:0] map_data;
    logic [10*NG-1:0] ghost_x, ghost_y;
    logic [TT*4-1:0] background_r, background_g, background_b, wall_r, wall_g, wall_b;
    logic [TT-1:0] player_mask_f1, player_mask_f2, ghost_mask_f1, ghost_mask_f2, dot_mask, big_dot_mask;
    logic [3:0] rgb_r, rgb_g, rgb_b;
    logic rgb_valid, anim_phase;

    logic [1:0] map_mem [MAP_N];

    typedef struct {
        int r;
        int g;
        int b;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;
    int last_r = 0, last_g = 0, last_b = 0;

    tile_pixel_scheduler #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .NUM_GHOSTS(NG), .ANIM_FRAMES(AF), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .map_addr(map_addr), .map_data(map_data),
        .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .background_r(background_r), .background_g(background_g), .background_b(background_b),
        .wall_r(wall_r), .wall_g(wall_g), .wall_b(wall_b),
        .player_mask_f1(player_mask_f1), .player_mask_f2(player_mask_f2),
        .ghost_mask_f1(ghost_mask_f1), .ghost_mask_f2(ghost_mask_f2),
        .dot_mask(dot_mask), .big_dot_mask(big_dot_mask),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .rgb_valid(rgb_valid), .anim_phase(anim_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The DUT's registered map_addr is the RAM address register, so the array read completes the 1-cycle RAM.
    assign map_data = (int'(map_addr) < MAP_N) ? map_mem[map_addr] : 2'd0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit spr(input int px, input int py, input int sx, input int sy, input logic [TT-1:0] m);
        int dx = px - sx;
        int dy = py - sy;
        if (dx < 0 || dx >= T || dy < 0 || dy >= T) return 1'b0;
        return m[dy*T + dx];
    endfunction

    function automatic bit phase_of(input int k);
        return ((k / AF) % 2) == 1;
    endfunction

    // Reference colour for pixel (px,py) rendered with the mask set after k frame pulses.
    function automatic exp_t model(input int px, input int py, input int k);
        exp_t e;
        bit ph = phase_of(k);
        int tx = px / T;
        int ty = py / T;
        int off = (py % T) * T + (px % T);
        int code;
        int br, bgc, bb;
        bit ghit = 1'b0;
        if (tx >= MAP_W || ty >= MAP_H) begin
            code = 0; br = 0; bgc = 0; bb = 0;
        end else begin
            code = int'(map_mem[ty*MAP_W + tx]);
            br = int'(background_r[off*4 +: 4]);
            bgc = int'(background_g[off*4 +: 4]);
            bb = int'(background_b[off*4 +: 4]);
        end
        for (int g = 0; g < NG; g++)
            if (spr(px, py, int'(ghost_x[g*10 +: 10]), int'(ghost_y[g*10 +: 10]),
                    ph ? ghost_mask_f2 : ghost_mask_f1)) ghit = 1'b1;
        e.r = br; e.g = bgc; e.b = bb; e.cyc = 0;
        if (spr(px, py, int'(player_x), int'(player_y), ph ? player_mask_f2 : player_mask_f1)) begin
            e.r = 15; e.g = 15; e.b = 0;
        end else if (ghit) begin
            e.r = 15; e.g = 0; e.b = 0;
        end else if (code == 1) begin
            e.r = int'(wall_r[off*4 +: 4]); e.g = int'(wall_g[off*4 +: 4]); e.b = int'(wall_b[off*4 +: 4]);
        end else if ((code == 2 && dot_mask[off]) || (code == 3 && big_dot_mask[off])) begin
            e.r = 15; e.g = 15; e.b = 15;
        end
        return e;
    endfunction

    // Monitor: pop and compare on every valid output, check hold on every bubble.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_r = 0; last_g = 0; last_b = 0;
        end else if (rgb_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rgb_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rgb_r", int'(rgb_r), mon_e.r);
                chk("rgb_g", int'(rgb_g), mon_e.g);
                chk("rgb_b", int'(rgb_b), mon_e.b);
                chk("latency_cycle", cyc, mon_e.cyc);
                last_r = mon_e.r; last_g = mon_e.g; last_b = mon_e.b;
            end
        end else begin
            chk("hold_r", int'(rgb_r), last_r);
            chk("hold_g", int'(rgb_g), last_g);
            chk("hold_b", int'(rgb_b), last_b);
        end
    end

    task automatic issue(input int x, input int y, input bit fs);
        exp_t e;
        @(posedge clk); #1;
        pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y); frame_start = fs;
        e = model(x, y, pulses);
        e.cyc = cyc + 2;
        sbq.push_back(e);
        if (fs) pulses++;
    endtask

    task automatic idle(input bit fs);
        @(posedge clk); #1;
        pix_valid = 1'b0; frame_start = fs;
        if (fs) pulses++;
    endtask

    task automatic drain();
        repeat (4) idle(1'b0);
    endtask

    task automatic set_ghost(input int k, input int x, input int y);
        ghost_x[k*10 +: 10] = 10'(x);
        ghost_y[k*10 +: 10] = 10'(y);
    endtask

    task automatic park_sprites();
        player_x = 10'(PARK); player_y = 10'(PARK);
        for (int k = 0; k < NG; k++) set_ghost(k, PARK, PARK);
    endtask

    task automatic randomize_scene();
        for (int i = 0; i < MAP_N; i++) map_mem[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < TT*4; i++) begin
            background_r[i] = 1'($urandom); background_g[i] = 1'($urandom); background_b[i] = 1'($urandom);
            wall_r[i] = 1'($urandom); wall_g[i] = 1'($urandom); wall_b[i] = 1'($urandom);
        end
        for (int i = 0; i < TT; i++) begin
            player_mask_f1[i] = 1'($urandom); player_mask_f2[i] = 1'($urandom);
            ghost_mask_f1[i] = 1'($urandom); ghost_mask_f2[i] = 1'($urandom);
            dot_mask[i] = 1'($urandom); big_dot_mask[i] = 1'($urandom);
        end
        player_x = 10'($urandom_range(0, 255)); player_y = 10'($urandom_range(0, 255));
        for (int k = 0; k < NG; k++) set_ghost(k, $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
        ghost_x = '0; ghost_y = '0; player_x = 10'd0; player_y = 10'd0;
        randomize_scene();
        park_sprites();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_map_addr", int'(map_addr), 0);
        chk("reset_rgb", int'({rgb_r, rgb_g, rgb_b}), 0);
        chk("reset_rgb_valid", int'(rgb_valid), 0);
        chk("reset_anim_phase", int'(anim_phase), 0);
        rst_n = 1'b1;

        // Wall at tile 0, pixel (0,0).
        map_mem[0] = 2'd1;
        issue(0, 0, 1'b0);
        idle(1'b0);
        chk("t1_map_addr", int'(map_addr), 0);
        drain();

        // Dot tile at (3,1), offset 5*T+2 opaque.
        map_mem[MAP_W + 3] = 2'd2;
        dot_mask[5*T + 2] = 1'b1;
        issue(T*3 + 2, T*1 + 5, 1'b0);
        idle(1'b0);
        chk("t2_map_addr", int'(map_addr), MAP_W + 3);
        drain();

        // Player over ghost, then ghost alone.
        player_mask_f1 = '1; player_mask_f2 = '1; ghost_mask_f1 = '1; ghost_mask_f2 = '1;
        player_x = 10'd40; player_y = 10'd40; set_ghost(0, 40, 40);
        issue(45, 45, 1'b0);
        drain();
        player_x = 10'd100; player_y = 10'd100;
        issue(45, 45, 1'b0);
        issue(47, 47, 1'b0);
        issue(48, 45, 1'b0);
        drain();

        // Animation phase with ANIM_FRAMES=2 and pixels coincident with pulses.
        park_sprites();
        player_x = 10'd16; player_y = 10'd16;
        player_mask_f1 = '1; player_mask_f2 = '0;
        idle(1'b0);
        chk("anim_phase_0", int'(anim_phase), int'(phase_of(pulses)));
        idle(1'b1); idle(1'b0);
        chk("anim_phase_1", int'(anim_phase), int'(phase_of(pulses)));
        issue(18, 18, 1'b1);
        idle(1'b0);
        chk("anim_phase_2", int'(anim_phase), int'(phase_of(pulses)));
        issue(18, 18, 1'b0);
        idle(1'b1); idle(1'b0);
        chk("anim_phase_3", int'(anim_phase), int'(phase_of(pulses)));
        issue(18, 18, 1'b1);
        idle(1'b0);
        chk("anim_phase_4", int'(anim_phase), int'(phase_of(pulses)));
        issue(18, 18, 1'b0);
        drain();

        // Out of map: black background, sprites still drawn.
        park_sprites();
        issue(MAP_W*T, 0, 1'b0);
        issue(0, MAP_H*T, 1'b0);
        player_mask_f1 = '1; player_mask_f2 = '1;
        drain();
        player_x = 10'(MAP_W*T - 2); player_y = 10'd0;
        issue(MAP_W*T, 0, 1'b0);
        issue(MAP_W*T + 5, 3, 1'b0);
        issue(MAP_W*T + 6, 0, 1'b0);
        drain();

        // Randomized scenes and streams.
        for (int b = 0; b < 4; b++) begin
            randomize_scene();
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 15) == 0);
                else issue($urandom_range(0, 260), $urandom_range(0, 260), $urandom_range(0, 15) == 0);
            end
            drain();
        end

        // Reset pulse in the middle of a continuous stream.
        randomize_scene();
        while (!phase_of(pulses)) idle(1'b1);
        idle(1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                @(posedge clk); #1;
                chk("pre_reset_rgb_valid", int'(rgb_valid), 1);
                rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
                sbq.delete();
                pulses = 0;
                #1;
                chk("reset_mid_rgb_valid", int'(rgb_valid), 0);
                chk("reset_mid_anim_phase", int'(anim_phase), 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                issue($urandom_range(0, 260), $urandom_range(0, 260), 1'b0);
            end
        end

        for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1'b0);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
